// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of the single-port RAM256x64: the datapath (CPU) has priority,
// and a starvation counter forces one DMA access after STARVE_LIMIT contested losses.
module ram_arbiter #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [3:0]        starve_cnt
);

    typedef enum logic [0:0] {
        CPU_PRI   = 1'b0,
        DMA_FORCE = 1'b1
    } state_t;

    localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);

    state_t      state_r;
    state_t      state_nxt_s;
    logic [3:0]  starve_cnt_r;
    logic [3:0]  starve_cnt_nxt_s;
    logic        force_dma_s;
    logic        cpu_win_s;
    logic        dma_win_s;
    logic        cpu_gnt_s;
    logic        dma_gnt_s;
    logic        cpu_rvalid_r;
    logic        dma_rvalid_r;
    logic [DATA_W-1:0] cpu_rdata_r;
    logic [DATA_W-1:0] dma_rdata_r;

    // Winner selection; the raw winner still steers the RAM mux during reset, grants do not.
    always_comb begin
        force_dma_s = (state_r == DMA_FORCE);
        dma_win_s   = dma_req & (~cpu_req | force_dma_s);
        cpu_win_s   = cpu_req & ~dma_win_s;
        cpu_gnt_s   = cpu_win_s & ~rst;
        dma_gnt_s   = dma_win_s & ~rst;
    end

    // RAM address/data/write-enable mux from the winning port.
    always_comb begin
        ram_addr  = {ADDR_W{1'b0}};
        ram_wdata = {DATA_W{1'b0}};
        ram_we    = 1'b0;
        if (dma_win_s) begin
            ram_addr  = dma_addr;
            ram_wdata = dma_wdata;
            ram_we    = dma_we & dma_gnt_s;
        end else if (cpu_win_s) begin
            ram_addr  = cpu_addr;
            ram_wdata = cpu_wdata;
            ram_we    = cpu_we & cpu_gnt_s;
        end else begin
            ram_we    = 1'b0;
        end
    end

    // Starvation next-state: count contested CPU wins, force exactly one DMA slot.
    always_comb begin
        state_nxt_s      = CPU_PRI;
        starve_cnt_nxt_s = 4'd0;
        case (state_r)
            CPU_PRI: begin
                if (cpu_gnt_s && dma_req) begin
                    if ((starve_cnt_r + 4'd1) == LIMIT_C) begin
                        state_nxt_s = DMA_FORCE;
                    end else begin
                        starve_cnt_nxt_s = starve_cnt_r + 4'd1;
                    end
                end else begin
                    starve_cnt_nxt_s = 4'd0;
                end
            end
            DMA_FORCE: begin
                // Leaves after one cycle whether DMA used the slot or withdrew.
                state_nxt_s      = CPU_PRI;
                starve_cnt_nxt_s = 4'd0;
            end
            default: begin
                state_nxt_s      = CPU_PRI;
                starve_cnt_nxt_s = 4'd0;
            end
        endcase
    end

    // Starvation state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= CPU_PRI;
            starve_cnt_r <= 4'd0;
        end else begin
            state_r      <= state_nxt_s;
            starve_cnt_r <= starve_cnt_nxt_s;
        end
    end

    // Read-data return registers; rvalid pulses for the cycle after a granted read.
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_rvalid_r <= 1'b0;
            dma_rvalid_r <= 1'b0;
            cpu_rdata_r  <= {DATA_W{1'b0}};
            dma_rdata_r  <= {DATA_W{1'b0}};
        end else begin
            cpu_rvalid_r <= cpu_gnt_s & ~cpu_we;
            dma_rvalid_r <= dma_gnt_s & ~dma_we;
            if (cpu_gnt_s && !cpu_we) begin
                cpu_rdata_r <= ram_rdata;
            end
            if (dma_gnt_s && !dma_we) begin
                dma_rdata_r <= ram_rdata;
            end
        end
    end

    assign cpu_gnt    = cpu_gnt_s;
    assign dma_gnt    = dma_gnt_s;
    assign cpu_stall  = cpu_req & ~cpu_gnt_s;
    assign cpu_rvalid = cpu_rvalid_r;
    assign dma_rvalid = dma_rvalid_r;
    assign cpu_rdata  = cpu_rdata_r;
    assign dma_rdata  = dma_rdata_r;
    assign starve_cnt = starve_cnt_r;

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized and directed bench for ram_arbiter, checked against a behavioural model
// (per-cycle winner, loss counter, memory array) kept in the bench.
module tb_ram_arbiter;

    localparam int LIMIT = 4;

    logic        clk;
    logic        rst;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [7:0]  cpu_addr, dma_addr;
    logic [63:0] cpu_wdata, dma_wdata;
    logic        cpu_gnt, cpu_stall, cpu_rvalid, dma_gnt, dma_rvalid, ram_we;
    logic [63:0] cpu_rdata, dma_rdata, ram_wdata, ram_rdata;
    logic [7:0]  ram_addr;
    logic [3:0]  starve_cnt;

    logic [63:0] mem     [256];
    logic [63:0] ref_mem [256];

    int          checks;
    int          errors;

    bit          m_forced;
    int          m_lost;
    logic        m_crv, m_drv;
    logic [63:0] m_crd, m_drd;

    ram_arbiter #(.ADDR_W(8), .DATA_W(64), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
        .starve_cnt(starve_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM: combinational read, write at the clock edge.
    assign ram_rdata = mem[ram_addr];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_cpu(input logic req, input logic we, input logic [7:0] a, input logic [63:0] d);
        cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic set_dma(input logic req, input logic we, input logic [7:0] a, input logic [63:0] d);
        dma_req = req; dma_we = we; dma_addr = a; dma_wdata = d;
    endtask

    // One cycle: check outputs against the model, take the edge, advance the model.
    task automatic step(output bit cg, output bit dg);
        bit          cw, dw;
        logic        ewe;
        logic [7:0]  ea;
        logic [63:0] ed;
        #1;
        dw  = dma_req & (~cpu_req | m_forced);
        cw  = cpu_req & ~dw;
        ea  = dw ? dma_addr  : (cw ? cpu_addr  : 8'd0);
        ed  = dw ? dma_wdata : (cw ? cpu_wdata : 64'd0);
        ewe = (dw ? dma_we : (cw ? cpu_we : 1'b0)) & ~rst;
        check_eq("cpu_gnt",    64'(cpu_gnt),    64'(cw & ~rst));
        check_eq("dma_gnt",    64'(dma_gnt),    64'(dw & ~rst));
        check_eq("ram_we",     64'(ram_we),     64'(ewe));
        check_eq("cpu_stall",  64'(cpu_stall),  64'(cpu_req & ~(cw & ~rst)));
        check_eq("starve_cnt", 64'(starve_cnt), 64'(m_lost));
        check_eq("cpu_rvalid", 64'(cpu_rvalid), 64'(m_crv));
        check_eq("dma_rvalid", 64'(dma_rvalid), 64'(m_drv));
        check_eq("cpu_rdata",  cpu_rdata,       m_crd);
        check_eq("dma_rdata",  dma_rdata,       m_drd);
        if (!rst) begin
            check_eq("ram_addr",  64'(ram_addr), 64'(ea));
            check_eq("ram_wdata", ram_wdata,     ed);
        end
        @(posedge clk);
        cg = cw & ~rst;
        dg = dw & ~rst;
        if (rst) begin
            m_forced = 1'b0; m_lost = 0;
            m_crv = 1'b0; m_drv = 1'b0; m_crd = 64'd0; m_drd = 64'd0;
        end else begin
            m_crv = cw & ~cpu_we;
            m_drv = dw & ~dma_we;
            if (m_crv) m_crd = ref_mem[cpu_addr];
            if (m_drv) m_drd = ref_mem[dma_addr];
            if (cw && cpu_we) ref_mem[cpu_addr] = cpu_wdata;
            if (dw && dma_we) ref_mem[dma_addr] = dma_wdata;
            if (m_forced) begin
                m_forced = 1'b0; m_lost = 0;
            end else if (cpu_req && dma_req) begin
                m_lost++;
                if (m_lost == LIMIT) begin
                    m_forced = 1'b1; m_lost = 0;
                end
            end else begin
                m_lost = 0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        bit cg, dg;
        bit cpend, dpend;
        int n, dcount;
        int exp_seq[10] = '{1, 2, 3, 0, 0, 1, 2, 3, 0, 0};
        checks = 0; errors = 0;
        m_forced = 1'b0; m_lost = 0;
        m_crv = 1'b0; m_drv = 1'b0; m_crd = 64'd0; m_drd = 64'd0;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 64'd0; ref_mem[i] = 64'd0;
        end
        rst = 1'b1;
        set_cpu(1'b0, 1'b0, 8'd0, 64'd0);
        set_dma(1'b0, 1'b0, 8'd0, 64'd0);
        @(negedge clk);
        step(cg, dg);
        step(cg, dg);
        rst = 1'b0;

        // Idle: no grants, no writes, address parked at zero.
        for (int i = 0; i < 10; i++) step(cg, dg);

        // CPU write then read of address 5.
        set_cpu(1'b1, 1'b1, 8'd5, 64'hDEADBEEF_00000001);
        step(cg, dg);
        check_eq("t1_wr_gnt", 64'(cg), 64'd1);
        set_cpu(1'b1, 1'b0, 8'd5, 64'd0);
        step(cg, dg);
        check_eq("t1_rd_gnt", 64'(cg), 64'd1);
        set_cpu(1'b0, 1'b0, 8'd0, 64'd0);
        check_eq("t1_rvalid", 64'(cpu_rvalid), 64'd1);
        check_eq("t1_rdata",  cpu_rdata, 64'hDEADBEEF_00000001);
        step(cg, dg);

        // DMA preload 0x1234 at 0xFF, then DMA read back.
        set_dma(1'b1, 1'b1, 8'hFF, 64'h1234);
        step(cg, dg);
        set_dma(1'b1, 1'b0, 8'hFF, 64'd0);
        step(cg, dg);
        check_eq("t2_gnt", 64'(dg), 64'd1);
        set_dma(1'b0, 1'b0, 8'd0, 64'd0);
        check_eq("t2_rvalid", 64'(dma_rvalid), 64'd1);
        check_eq("t2_rdata",  dma_rdata, 64'h1234);
        step(cg, dg);

        // Continuous contention: 4 CPU wins, then one forced DMA slot, repeating.
        set_cpu(1'b1, 1'b0, 8'd5, 64'd0);
        set_dma(1'b1, 1'b0, 8'hFF, 64'd0);
        dcount = 0;
        for (int i = 0; i < 10; i++) begin
            step(cg, dg);
            if (dg) dcount++;
            check_eq($sformatf("t3_cnt%0d", i), 64'(starve_cnt), 64'(exp_seq[i]));
        end
        check_eq("t3_dma_slots", 64'(dcount), 64'd2);

        // Two losses, DMA withdraws for one cycle, then needs 4 fresh losses.
        step(cg, dg);
        step(cg, dg);
        dma_req = 1'b0;
        step(cg, dg);
        check_eq("t4_cleared", 64'(starve_cnt), 64'd0);
        dma_req = 1'b1;
        n = 0;
        dg = 1'b0;
        while (!dg && n < 20) begin
            step(cg, dg);
            n++;
        end
        check_eq("t4_wait", 64'(n), 64'd5);

        // Reset while forced with a CPU read result pending.
        for (int i = 0; i < LIMIT; i++) step(cg, dg);
        rst = 1'b1;
        step(cg, dg);
        rst = 1'b0;
        check_eq("t5_crv", 64'(cpu_rvalid), 64'd0);
        check_eq("t5_drv", 64'(dma_rvalid), 64'd0);
        check_eq("t5_crd", cpu_rdata, 64'd0);
        check_eq("t5_drd", dma_rdata, 64'd0);
        check_eq("t5_cnt", 64'(starve_cnt), 64'd0);
        step(cg, dg);
        check_eq("t5_cpu_wins", 64'(cg), 64'd1);

        // Random traffic; an ungranted request is held unchanged.
        cpend = 1'b0; dpend = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (!cpend) begin
                set_cpu(($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0, 1'($urandom_range(0, 1)),
                        8'($urandom_range(0, 31)), {$urandom, $urandom});
                cpend = cpu_req;
            end
            if (!dpend) begin
                set_dma(($urandom_range(0, 99) < 50) ? 1'b1 : 1'b0, 1'($urandom_range(0, 1)),
                        8'($urandom_range(0, 31)), {$urandom, $urandom});
                dpend = dma_req;
            end
            rst = ($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0;
            step(cg, dg);
            if (cg) cpend = 1'b0;
            if (dg) dpend = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
